// File: rtl/if_pkg.sv
// +------------------------------------------------------------------+
// | if_pkg: shared types and constants for the instruction fetch stage |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package if_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    ERR   = 3'd4
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_fetch.sv
// +------------------------------------------------------------------+
// | if_fetch: PC-driven instruction fetch with valid/ready decode port |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module if_fetch
  import if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ena,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              fault
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic         w_misaligned;
  logic         w_latch_addr;
  logic         w_capture;

  assign w_misaligned = (pc_in[1:0] & ALIGN_MASK) != 2'b00;

  always_comb begin
    w_next_state = r_state;
    w_latch_addr = 1'b0;
    w_capture    = 1'b0;
    // Gated by rst so the PC register never advances in a reset cycle.
    pc_ena       = rst && (r_state == HOLD) && id_ready && !flush;

    case (r_state)
      IDLE: begin
        if (!flush) begin
          if (w_misaligned) begin
            w_next_state = ERR;
          end else begin
            w_next_state = REQ;
            w_latch_addr = 1'b1;
          end
        end
      end
      REQ: begin
        if (flush) begin
          // A flushed request still owes the memory its acknowledge.
          w_next_state = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          w_next_state = HOLD;
          w_capture    = 1'b1;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          w_next_state = IDLE;
        end
      end
      HOLD: begin
        if (flush || id_ready) begin
          w_next_state = IDLE;
        end
      end
      ERR: begin
        if (flush) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs are pure functions of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= '0;
      fault     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      imem_req <= (w_next_state == REQ) || (w_next_state == DRAIN);
      id_valid <= (w_next_state == HOLD);
      fault    <= (w_next_state == ERR);
      if (w_latch_addr) begin
        imem_addr <= pc_in;
      end
      if (w_capture) begin
        id_instr <= imem_rdata;
        id_pc    <= imem_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// +------------------------------------------------------------------+
// | tb_if_fetch: directed and randomized checks of if_fetch            |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        fault;

  logic [31:0] pc_q;
  logic [31:0] flush_tgt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // PC register model: redirect wins over advance.
  always @(posedge clk) begin
    if (!rst)           pc_q <= 32'h10;
    else if (flush)     pc_q <= flush_tgt;
    else if (pc_ena)    pc_q <= pc_q + 32'd4;
  end
  assign pc_in = pc_q;

  if_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_ena(pc_ena), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .fault(fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;
  int          accepted;
  int          fault_seen;

  initial begin
    rst = 1'b0; flush = 1'b0; flush_tgt = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b1;

    // Reset held for two edges, with decode ready to prove pc_ena stays low
    step; step; #1;
    chk1 ("rst_req",    imem_req, 1'b0);
    chk1 ("rst_valid",  id_valid, 1'b0);
    chk1 ("rst_fault",  fault,    1'b0);
    chk1 ("rst_pc_ena", pc_ena,   1'b0);
    chk32("rst_addr",   imem_addr, 32'h0);
    chk32("rst_instr",  id_instr,  32'h0);
    chk32("rst_id_pc",  id_pc,     32'h0);
    rst = 1'b1; id_ready = 1'b0;

    // Normal fetch, ack in first REQ cycle
    step; imem_ack = 1'b1; imem_rdata = 32'h20080005; id_ready = 1'b1; #1;
    chk1 ("c1_req", imem_req, 1'b1);
    chk32("c1_addr", imem_addr, 32'h10);
    chk1 ("c1_no_ena", pc_ena, 1'b0);
    step; imem_ack = 1'b0; #1;
    chk1 ("c1_valid", id_valid, 1'b1);
    chk32("c1_instr", id_instr, 32'h20080005);
    chk32("c1_id_pc", id_pc, 32'h10);
    chk1 ("c1_req_low", imem_req, 1'b0);
    chk1 ("c1_ena", pc_ena, 1'b1);
    step; id_ready = 1'b0; #1;
    chk1 ("c1_valid_clr", id_valid, 1'b0);
    chk1 ("c1_ena_pulse", pc_ena, 1'b0);
    step; #1;
    chk1 ("c2_req", imem_req, 1'b1);
    chk32("c2_addr", imem_addr, 32'h14);

    // Slow memory (3 wait cycles) then decode backpressure for 4 cycles
    for (int i = 0; i < 2; i++) begin
      step; #1;
      chk1 ("bp_wait_req", imem_req, 1'b1);
      chk32("bp_wait_addr", imem_addr, 32'h14);
      chk1 ("bp_wait_valid", id_valid, 1'b0);
    end
    step; imem_ack = 1'b1; imem_rdata = 32'h12345678; #1;
    chk1 ("bp_ack_req", imem_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step; imem_ack = 1'b0; #1;
      chk1 ("bp_valid", id_valid, 1'b1);
      chk32("bp_instr", id_instr, 32'h12345678);
      chk32("bp_id_pc", id_pc, 32'h14);
      chk1 ("bp_no_ena", pc_ena, 1'b0);
    end
    step; id_ready = 1'b1; #1;
    chk1 ("bp_ena", pc_ena, 1'b1);
    step; id_ready = 1'b0; #1;
    chk1 ("bp_valid_clr", id_valid, 1'b0);
    chk1 ("bp_ena_once", pc_ena, 1'b0);

    // Flush in REQ with no ack; memory answers two cycles later
    step; #1;
    chk32("fr_addr", imem_addr, 32'h18);
    flush = 1'b1; flush_tgt = 32'h100; #1;
    chk1 ("fr_no_ena", pc_ena, 1'b0);
    step; flush = 1'b0; #1;
    chk1 ("fr_drain_req", imem_req, 1'b1);
    chk32("fr_drain_addr", imem_addr, 32'h18);
    step; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; #1;
    chk1 ("fr_drain_req2", imem_req, 1'b1);
    chk1 ("fr_no_valid", id_valid, 1'b0);
    step; imem_ack = 1'b0; #1;
    chk1 ("fr_req_drop", imem_req, 1'b0);
    chk1 ("fr_no_valid2", id_valid, 1'b0);
    step; #1;
    chk1 ("fr_new_req", imem_req, 1'b1);
    chk32("fr_new_addr", imem_addr, 32'h100);

    // Flush and ready together in HOLD
    imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
    step; imem_ack = 1'b0; flush = 1'b1; flush_tgt = 32'h200; id_ready = 1'b1; #1;
    chk1 ("fh_valid", id_valid, 1'b1);
    chk32("fh_instr", id_instr, 32'hCAFEF00D);
    chk1 ("fh_no_ena", pc_ena, 1'b0);
    step; flush = 1'b0; id_ready = 1'b0; #1;
    chk1 ("fh_valid_clr", id_valid, 1'b0);
    chk1 ("fh_idle_req", imem_req, 1'b0);
    step; #1;
    chk32("fh_redirect", imem_addr, 32'h200);
    imem_ack = 1'b1; imem_rdata = 32'h0BADC0DE;

    // Misaligned redirect, then recovery by flush
    step; imem_ack = 1'b0; flush = 1'b1; flush_tgt = 32'h12; #1;
    chk32("mis_id_pc", id_pc, 32'h200);
    step; flush = 1'b0; #1;
    chk1 ("mis_fault_pre", fault, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step; #1;
      chk1 ("mis_fault", fault, 1'b1);
      chk1 ("mis_no_req", imem_req, 1'b0);
    end
    flush = 1'b1; flush_tgt = 32'h20;
    step; flush = 1'b0; #1;
    chk1 ("mis_fault_clr", fault, 1'b0);
    step; #1;
    chk1 ("mis_req", imem_req, 1'b1);
    chk32("mis_addr", imem_addr, 32'h20);

    // Reset with a request outstanding
    rst = 1'b0;
    step; #1;
    chk1 ("rmid_req", imem_req, 1'b0);
    rst = 1'b1;
    step; #1;
    chk32("rmid_addr", imem_addr, 32'h10);

    // Randomized traffic against the PC register / memory model
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
    accepted = 0; fault_seen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step;
      flush     = ($urandom_range(0, 15) == 0);
      flush_tgt = (32'($urandom_range(0, 255)) << 2) |
                  (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      id_ready  = $urandom_range(0, 1) == 1;
      imem_ack  = imem_req && ($urandom_range(0, 2) == 0);
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
      #1;
      chk1("rnd_pc_ena", pc_ena, id_valid && id_ready && !flush);
      if (id_valid) begin
        chk32("rnd_id_pc", id_pc, pc_in);
        chk32("rnd_instr", id_instr, mem_word(id_pc));
        if (id_ready && !flush) accepted++;
      end
      if (imem_req) begin
        chk32("rnd_addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (prev_req && !prev_ack) chk32("rnd_addr_hold", imem_addr, prev_addr);
      end
      if (fault) begin
        fault_seen++;
        chk1("rnd_fault_noreq", imem_req, 1'b0);
        chk1("rnd_fault_pc", pc_in[1:0] != 2'b00, 1'b1);
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
    chk1("rnd_progress", accepted > 100, 1'b1);
    chk1("rnd_fault_hit", fault_seen > 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC from the PC register's data_out and issues one request/acknowledge read to instruction memory.
- Holds the returned word in a valid/ready output register for decode.
- Drives the PC register's ena, so the PC advances only when decode accepts an instruction.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction word width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset. rst==0 at a rising edge resets the block.
- pc_in  in  ADDR_W  current PC; connects to PC register data_out.
- pc_ena  out  1  advance strobe; connects to PC register ena.
- flush  in  1  redirect/abort from the branch unit.
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_W  request address; stable while imem_req=1.
- imem_ack  in  1  memory acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  DATA_W  memory read data.
- id_valid  out  1  instruction valid to decode.
- id_ready  in  1  decode accepts.
- id_instr  out  DATA_W  fetched instruction.
- id_pc  out  ADDR_W  PC of id_instr.
- fault  out  1  sticky misaligned-PC flag.

Behaviour:
- Reset (rst==0 at edge): state=IDLE. pc_ena, imem_req, id_valid and fault = 0. imem_addr, id_instr and id_pc = 0.
- States: IDLE, REQ, DRAIN, HOLD, ERR. All outputs are registered except pc_ena, which is combinational from state/id_ready/flush.
- IDLE:
  - pc_in[1:0]!=0 -> ERR; fault<=1.
  - Otherwise imem_addr<=pc_in, imem_req<=1 -> REQ.
- REQ:
  - imem_req=1; imem_addr is held.
  - On imem_ack: id_instr<=imem_rdata, id_pc<=imem_addr, imem_req<=0, id_valid<=1 -> HOLD.
  - No ack -> stay in REQ. Waits are unbounded; there is no timeout.
- HOLD:
  - id_valid=1; id_instr and id_pc are stable.
  - id_ready=1 -> pc_ena=1 for exactly that cycle, id_valid<=0 -> IDLE. The PC register loads the next PC at the same edge, so IDLE sees the new pc_in.
- DRAIN:
  - imem_req stays 1 with the same address (the memory handshake must not be abandoned).
  - On imem_ack: discard data, imem_req<=0 -> IDLE.
- ERR:
  - No requests are issued; fault=1.
  - Leave only on flush -> IDLE, fault<=0.
- Flush rules (flush has priority over every other event in the same cycle):
  - IDLE: stay in IDLE; no request is latched that cycle.
  - REQ without ack: -> DRAIN.
  - REQ with ack: data discarded, imem_req<=0 -> IDLE.
  - HOLD: id_valid<=0 -> IDLE; pc_ena=0 even if id_ready=1, because the redirect writes the PC.
  - DRAIN: stay in DRAIN.
  - ERR: clear fault -> IDLE.
- pc_ena is 1 only in HOLD with id_ready=1 and flush=0. It is never asserted during reset.
- Latency:
  - IDLE->req: 1 cycle.
  - ack -> id_valid: next edge.
  - Best case with ack in the first REQ cycle: 3 cycles per instruction.
- Reset mid-operation: an outstanding request is dropped immediately (imem_req=0). The memory must tolerate request withdrawal on reset.
- No arithmetic is done here; the next-PC computation lives upstream of the PC register.

Decomposition:
- Shared package if_pkg holds:
  - the state encoding constants (IDLE, REQ, DRAIN, HOLD, ERR; 3 bits);
  - ALIGN_MASK=2'b11;
  - the default ADDR_W/DATA_W.
- Single module; no sub-module is warranted. The FSM and output register sit together in one always block plus the combinational pc_ena.

Test Plan:
- Reset: hold rst=0 for 2 cycles with pc_in=0x00000010 -> all outputs 0. Release -> imem_req=1, imem_addr=0x10 one cycle later.
- Normal fetch: ack on the first REQ cycle with rdata=0x20080005, id_ready=1 -> id_valid=1, id_instr=0x20080005, id_pc=0x10. One-cycle pc_ena pulse; the next request uses the new pc_in=0x14.
- Backpressure + slow memory: ack after 3 wait cycles, id_ready=0 for 4 cycles -> id_instr/id_pc stable throughout, pc_ena=0 until the ready cycle, exactly one pc_ena pulse.
- Flush in REQ: flush with no ack, ack 2 cycles later with 0xDEADBEEF -> imem_req held through DRAIN, id_valid never 1, no pc_ena, then a new request at the redirected pc_in=0x100.
- Flush vs ready in HOLD: flush=1 and id_ready=1 in the same cycle -> pc_ena=0, id_valid=0 next cycle, state IDLE.
- Misaligned PC: pc_in=0x00000012 in IDLE -> fault=1, no imem_req. Flush with pc_in=0x20 -> fault=0, request to 0x20.
